// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage PC sequencer: picks the next PC (sequential, redirect, hold, halt),
// drives the imem fetch handshake and raises flush on taken redirects.
module pc_fetch_ctrl #(
  parameter int                ADDR_W   = 10,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  input  logic              halt_i,
  input  logic              resume_i,
  input  logic              imem_ready_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              fetch_valid_o,
  output logic              flush_o,
  output logic              misalign_o,
  output logic [1:0]        state_o,
  output logic [31:0]       fetch_count_o
);

  typedef enum logic [1:0] {
    BOOT = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10,
    ERR  = 2'b11
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] pc_n;
  logic [31:0]       count_n;
  logic              misalign_n;
  logic              accept;
  logic              redir_ok, redir_bad;

  assign redir_ok  = redirect_i && (redirect_pc_i[1:0] == 2'b00);
  assign redir_bad = redirect_i && (redirect_pc_i[1:0] != 2'b00);

  assign state_o       = state;
  assign fetch_valid_o = (state == RUN) && !stall_i;
  assign accept        = fetch_valid_o && imem_ready_i;
  // Flush even on a misaligned target: the wrong-path work still has to die.
  assign flush_o       = redirect_i && ((state == RUN) || (state == HALT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= BOOT;
      pc_o          <= RESET_PC;
      fetch_count_o <= '0;
      misalign_o    <= 1'b0;
    end else begin
      state         <= state_n;
      pc_o          <= pc_n;
      fetch_count_o <= count_n;
      misalign_o    <= misalign_n;
    end
  end

  always_comb begin
    state_n    = state;
    pc_n       = pc_o;
    count_n    = fetch_count_o;
    misalign_n = misalign_o;
    case (state)
      BOOT: state_n = RUN;
      RUN: begin
        if (redir_bad) begin
          misalign_n = 1'b1;
          state_n    = ERR;
        end else begin
          if (redir_ok) begin
            pc_n = redirect_pc_i;
          end else if (accept) begin
            pc_n    = pc_o + ADDR_W'(4);
            count_n = fetch_count_o + 32'd1;
          end
          if (halt_i) state_n = HALT;
        end
      end
      HALT: begin
        // Aligned redirects still land here so in-flight branches drain.
        if (redir_bad) begin
          misalign_n = 1'b1;
          state_n    = ERR;
        end else begin
          if (redir_ok) pc_n = redirect_pc_i;
          if (resume_i && !halt_i) state_n = RUN;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: one long vector table plus hand-written
// sequences for async reset, BOOT input masking and halt+redirect.
module tb_pc_fetch_ctrl;

  localparam logic [1:0] S_BOOT = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_HALT = 2'b10;
  localparam logic [1:0] S_ERR  = 2'b11;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_i, redirect_i, halt_i, resume_i, imem_ready_i;
  logic [9:0]  redirect_pc_i;
  logic [9:0]  pc_o;
  logic        fetch_valid_o, flush_o, misalign_o;
  logic [1:0]  state_o;
  logic [31:0] fetch_count_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pc_fetch_ctrl #(.ADDR_W(10), .RESET_PC(10'h000)) dut (
    .clk           (clk),
    .reset         (reset),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .halt_i        (halt_i),
    .resume_i      (resume_i),
    .imem_ready_i  (imem_ready_i),
    .pc_o          (pc_o),
    .fetch_valid_o (fetch_valid_o),
    .flush_o       (flush_o),
    .misalign_o    (misalign_o),
    .state_o       (state_o),
    .fetch_count_o (fetch_count_o)
  );

  typedef struct {
    logic        s, r;
    logic [9:0]  rp;
    logic        h, rs, rdy;
    logic [9:0]  pc;
    logic        v, f;
    logic [1:0]  st;
    logic [31:0] cnt;
    logic        m;
  } vec_t;

  vec_t tv[25];

  function automatic vec_t mk(input logic s, r, input logic [9:0] rp,
                              input logic h, rs, rdy, input logic [9:0] pc,
                              input logic v, f, input logic [1:0] st,
                              input int cnt, input logic m);
    vec_t t;
    t.s = s; t.r = r; t.rp = rp; t.h = h; t.rs = rs; t.rdy = rdy;
    t.pc = pc; t.v = v; t.f = f; t.st = st; t.cnt = 32'(cnt); t.m = m;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic s, r, input logic [9:0] rp, input logic h, rs, rdy);
    stall_i = s; redirect_i = r; redirect_pc_i = rp;
    halt_i = h; resume_i = rs; imem_ready_i = rdy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //          s r  rp      h rs rdy  pc      v f  st      cnt m
    tv[0]  = mk(0,0,10'h000,0,0,1, 10'h000,0,0,S_BOOT, 0, 0);
    tv[1]  = mk(0,0,10'h000,0,0,1, 10'h000,1,0,S_RUN,  0, 0);
    tv[2]  = mk(0,0,10'h000,0,0,1, 10'h004,1,0,S_RUN,  1, 0);
    tv[3]  = mk(0,0,10'h000,0,0,1, 10'h008,1,0,S_RUN,  2, 0);
    tv[4]  = mk(0,0,10'h000,0,0,1, 10'h00C,1,0,S_RUN,  3, 0);
    tv[5]  = mk(1,0,10'h000,0,0,1, 10'h010,0,0,S_RUN,  4, 0);
    tv[6]  = mk(1,0,10'h000,0,0,1, 10'h010,0,0,S_RUN,  4, 0);
    tv[7]  = mk(0,0,10'h000,0,0,0, 10'h010,1,0,S_RUN,  4, 0);
    tv[8]  = mk(0,0,10'h000,0,0,1, 10'h010,1,0,S_RUN,  4, 0);
    tv[9]  = mk(0,0,10'h000,0,0,1, 10'h014,1,0,S_RUN,  5, 0);
    tv[10] = mk(0,0,10'h000,0,0,1, 10'h018,1,0,S_RUN,  6, 0);
    tv[11] = mk(0,0,10'h000,0,0,1, 10'h01C,1,0,S_RUN,  7, 0);
    tv[12] = mk(1,1,10'h100,0,0,1, 10'h020,0,1,S_RUN,  8, 0);
    tv[13] = mk(0,1,10'h3FC,0,0,1, 10'h100,1,1,S_RUN,  8, 0);
    tv[14] = mk(0,0,10'h000,0,0,1, 10'h3FC,1,0,S_RUN,  8, 0);
    tv[15] = mk(0,1,10'h03C,0,0,1, 10'h000,1,1,S_RUN,  9, 0);
    tv[16] = mk(0,0,10'h000,0,0,1, 10'h03C,1,0,S_RUN,  9, 0);
    tv[17] = mk(0,0,10'h000,1,0,1, 10'h040,1,0,S_RUN, 10, 0);
    tv[18] = mk(0,1,10'h080,0,0,1, 10'h044,0,1,S_HALT,11, 0);
    tv[19] = mk(0,0,10'h000,1,1,1, 10'h080,0,0,S_HALT,11, 0);
    tv[20] = mk(0,0,10'h000,0,1,1, 10'h080,0,0,S_HALT,11, 0);
    tv[21] = mk(0,0,10'h000,0,0,1, 10'h080,1,0,S_RUN, 11, 0);
    tv[22] = mk(0,1,10'h102,0,0,1, 10'h084,1,1,S_RUN, 12, 0);
    tv[23] = mk(0,1,10'h200,1,1,1, 10'h084,0,0,S_ERR, 12, 1);
    tv[24] = mk(0,0,10'h000,0,1,1, 10'h084,0,0,S_ERR, 12, 1);

    reset = 1'b0;
    drive(0, 1, 10'h100, 0, 0, 1);
    #2;
    chk("rst_pc",    32'(pc_o), 32'h000);
    chk("rst_state", 32'(state_o), 32'(S_BOOT));
    chk("rst_valid", 32'(fetch_valid_o), 0);
    chk("rst_flush", 32'(flush_o), 0);
    chk("rst_mis",   32'(misalign_o), 0);
    chk("rst_cnt",   fetch_count_o, 0);
    #10;
    reset = 1'b1;

    for (int i = 0; i < 25; i++) begin
      drive(tv[i].s, tv[i].r, tv[i].rp, tv[i].h, tv[i].rs, tv[i].rdy);
      #1;
      chk($sformatf("v%0d_pc", i),    32'(pc_o),          32'(tv[i].pc));
      chk($sformatf("v%0d_valid", i), 32'(fetch_valid_o), 32'(tv[i].v));
      chk($sformatf("v%0d_flush", i), 32'(flush_o),       32'(tv[i].f));
      chk($sformatf("v%0d_state", i), 32'(state_o),       32'(tv[i].st));
      chk($sformatf("v%0d_cnt", i),   fetch_count_o,      tv[i].cnt);
      chk($sformatf("v%0d_mis", i),   32'(misalign_o),    32'(tv[i].m));
      step();
    end

    // Async reset from ERR: clears without waiting for a clock edge.
    #2;
    reset = 1'b0;
    #1;
    chk("arst_pc",    32'(pc_o), 32'h000);
    chk("arst_state", 32'(state_o), 32'(S_BOOT));
    chk("arst_mis",   32'(misalign_o), 0);
    chk("arst_cnt",   fetch_count_o, 0);

    // BOOT ignores a redirect and halt.
    drive(0, 1, 10'h100, 1, 0, 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("boot_flush", 32'(flush_o), 0);
    step();
    chk("boot_pc",    32'(pc_o), 32'h000);
    chk("boot_state", 32'(state_o), 32'(S_RUN));

    // Redirect and halt together: target loads, then HALT.
    drive(0, 1, 10'h0A0, 1, 0, 1);
    #1;
    chk("rh_flush", 32'(flush_o), 1);
    step();
    chk("rh_pc",    32'(pc_o), 32'h0A0);
    chk("rh_state", 32'(state_o), 32'(S_HALT));
    chk("rh_cnt",   fetch_count_o, 0);

    // Misaligned redirect while halted goes to ERR.
    drive(0, 1, 10'h0A1, 0, 0, 1);
    #1;
    chk("hm_flush", 32'(flush_o), 1);
    step();
    chk("hm_state", 32'(state_o), 32'(S_ERR));
    chk("hm_pc",    32'(pc_o), 32'h0A0);
    chk("hm_mis",   32'(misalign_o), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Fetch-stage sequencer that owns the program counter in the RV32I pipeline.
- Selects the next PC each cycle from these sources: sequential +4, branch/jump redirect from EX, stall hold, or halt.
- Drives the instruction-memory fetch handshake.
- Issues the flush pulse that kills younger instructions after a redirect.
- Sits between the hazard unit / EX branch resolver and instruction memory.

Parameters:
- ADDR_W, 10, width of the PC in bits; byte address; bits [1:0] are always 0.
- RESET_PC, 0, PC value loaded on reset; must be 4-byte aligned.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset; reset=0 forces the reset state immediately.
- stall_i  in  1  hazard-unit hold; the PC must not advance.
- redirect_i  in  1  taken branch/jump resolved in EX.
- redirect_pc_i  in  ADDR_W  redirect target address.
- halt_i  in  1  ebreak/ecall seen; stop fetching.
- resume_i  in  1  leave HALT.
- imem_ready_i  in  1  instruction memory accepts the address this cycle.
- pc_o  out  ADDR_W  current fetch address.
- fetch_valid_o  out  1  pc_o is a live fetch request.
- flush_o  out  1  kill IF/ID and ID/EX contents this cycle.
- misalign_o  out  1  sticky error: redirect target not 4-byte aligned.
- state_o  out  2  FSM state, encoded BOOT=00, RUN=01, HALT=10, ERR=11.
- fetch_count_o  out  32  number of accepted fetches.

Behaviour:
- Reset (reset=0, asynchronous) sets:
  - pc_o=RESET_PC, state=BOOT, misalign_o=0, fetch_count_o=0.
  - fetch_valid_o=0 and flush_o=0, since both follow state.
- BOOT:
  - Lasts exactly one cycle after reset deasserts, then goes to RUN.
  - fetch_valid_o=0; all inputs are ignored.
- fetch_valid_o is combinational: (state==RUN) && !stall_i.
- accept = fetch_valid_o && imem_ready_i.
- RUN next-PC priority, highest first:
  1. redirect_i=1 with redirect_pc_i[1:0]==0:
     - pc_o <= redirect_pc_i; fetch_count_o does not increment.
     - Overrides stall_i and imem_ready_i.
  2. redirect_i=1 with redirect_pc_i[1:0]!=0:
     - pc_o holds; misalign_o <= 1; state <= ERR.
  3. accept:
     - pc_o <= pc_o + 4, wrapping modulo 2^ADDR_W.
     - fetch_count_o increments, wrapping modulo 2^32.
  4. Otherwise (stall_i=1 or imem_ready_i=0): pc_o holds.
- flush_o is combinational: redirect_i && (state==RUN || state==HALT).
  - Asserted for every cycle redirect_i is high, including the misaligned case.
  - Never asserted in BOOT or ERR.
- halt_i in RUN: state <= HALT at the same edge as the PC update above.
  - Same-cycle redirect: the redirect target is still loaded, then the FSM halts.
  - Same-cycle accept: the +4 and count update still happen.
- HALT:
  - fetch_valid_o=0.
  - An aligned redirect_i still loads pc_o and asserts flush_o, so in-flight branches drain correctly.
  - A misaligned redirect goes to ERR as in RUN.
  - resume_i=1 and halt_i=0 → RUN next cycle.
  - resume_i and halt_i both high → stay in HALT.
- ERR:
  - fetch_valid_o=0 and flush_o=0; pc_o and fetch_count_o frozen; misalign_o=1.
  - Exit only via reset.
- Reset asserted mid-operation (any state, any cycle) takes effect immediately and overrides all inputs.
- The 2 LSBs of pc_o are always 0; there is no other arithmetic.

Test Plan:
- Reset/boot: reset=0 for 12 ns, then 1; stall_i=0, imem_ready_i=1.
  - Expect state BOOT for 1 cycle, then RUN.
  - Expect pc_o=0,4,8,12 on successive edges and fetch_count_o=1,2,3 in step.
- Stall/backpressure:
  - With pc_o=0x010, drive stall_i=1 for 2 cycles → pc_o stays 0x010 and fetch_valid_o=0.
  - Then imem_ready_i=0 for 1 cycle with stall_i=0 → fetch_valid_o=1, pc_o still 0x010, count unchanged; then advances to 0x014.
- Redirect over stall:
  - At pc_o=0x020, drive stall_i=1, redirect_i=1, redirect_pc_i=0x100 → flush_o=1 that cycle.
  - Next pc_o=0x100; fetch_count_o unchanged.
- Wrap: ADDR_W=10, redirect to 0x3FC, then accept → pc_o=0x000.
- Halt/resume:
  - halt_i=1 at pc_o=0x040 with accept → pc_o=0x044, state HALT, fetch_valid_o=0.
  - Aligned redirect to 0x080 while in HALT → pc_o=0x080, flush_o=1.
  - resume_i=1 → RUN, fetch from 0x080.
- Misalign and async reset:
  - redirect_pc_i=0x102 → flush_o=1, state ERR, misalign_o=1, pc_o frozen; halt_i and resume_i are ignored.
  - Pulse reset=0 mid-cycle → outputs clear immediately without a clock edge; pc_o=RESET_PC.
